// File: rtl/parity_chk_pkg.sv
// Shared state encodings and widths for the bit-serial parity checker.
package parity_chk_pkg;
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_PAR  = 2'd2,
    S_DONE = 2'd3
  } state_t;
endpackage

// File: rtl/gxor.sv
// Two-input XOR gate stage.
module gxor (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a ^ b;
endmodule

// File: rtl/par_acc_bit.sv
// XOR-feedback flop: folds one serial bit per enabled cycle into acc.
module par_acc_bit (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic d,
  output logic acc
);
  logic acc_nxt;

  gxor u_xor (.a(acc), .b(d), .y(acc_nxt));

  always_ff @(posedge clk) begin
    if (rst)      acc <= 1'b0;
    else if (clr) acc <= 1'b0;
    else if (en)  acc <= acc_nxt;
  end
endmodule

// File: rtl/parity_chk.sv
// Serial parity checker: NBITS data bits then one parity bit per frame,
// reports even/odd parity mismatch and a one-cycle done pulse.
module parity_chk
  import parity_chk_pkg::*;
#(
  parameter int NBITS = 8,
  parameter int ODD   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             bit_in,
  input  logic             bit_vld,
  output logic             busy,
  output logic             par_gen,
  output logic             done,
  output logic             par_err,
  output logic [CNT_W-1:0] cnt
);
  localparam logic             ODD_B = 1'(ODD);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(NBITS - 1);

  state_t           state, state_nxt;
  logic             acc_clr, acc_en, acc;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    acc_clr   = 1'b0;
    acc_en    = 1'b0;
    case (state)
      S_IDLE: if (start) begin
        state_nxt = S_DATA;
        acc_clr   = 1'b1;
      end
      S_DATA: if (bit_vld) begin
        acc_en = 1'b1;
        if (cnt_q == LAST) state_nxt = S_PAR;
      end
      S_PAR:  if (bit_vld) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  par_acc_bit u_acc (
    .clk(clk), .rst(rst), .clr(acc_clr), .en(acc_en), .d(bit_in), .acc(acc)
  );

  always_ff @(posedge clk) begin
    if (rst)          cnt_q <= '0;
    else if (acc_clr) cnt_q <= '0;
    else if (acc_en)  cnt_q <= cnt_q + CNT_W'(1);
  end

  // Verdict latched on parity acceptance; cleared only by a new frame or reset.
  always_ff @(posedge clk) begin
    if (rst)                             par_err <= 1'b0;
    else if (acc_clr)                    par_err <= 1'b0;
    else if (state == S_PAR && bit_vld)  par_err <= (acc ^ bit_in) != ODD_B;
  end

  assign busy    = (state == S_DATA) || (state == S_PAR);
  assign done    = (state == S_DONE);
  assign par_gen = acc ^ ODD_B;
  assign cnt     = cnt_q;
endmodule

// File: tb/tb_parity_chk.sv
// Directed bench for parity_chk: even (ODD=0) and odd (ODD=1) instances share stimulus.
module tb_parity_chk;
  logic       clk = 1'b0;
  logic       rst, start, bit_in, bit_vld;
  logic       busy0, gen0, done0, err0;
  logic       busy1, gen1, done1, err1;
  logic [7:0] cnt0, cnt1;
  logic       sel;
  logic       busy_s, gen_s, done_s, err_s;
  logic [7:0] cnt_s;
  int         n_tests = 0;
  int         n_fail  = 0;
  int         n_done  = 0;

  always #5 clk = ~clk;

  parity_chk #(.NBITS(8), .ODD(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .bit_in(bit_in), .bit_vld(bit_vld),
    .busy(busy0), .par_gen(gen0), .done(done0), .par_err(err0), .cnt(cnt0)
  );
  parity_chk #(.NBITS(8), .ODD(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .bit_in(bit_in), .bit_vld(bit_vld),
    .busy(busy1), .par_gen(gen1), .done(done1), .par_err(err1), .cnt(cnt1)
  );

  always_comb begin
    busy_s = sel ? busy1 : busy0;
    gen_s  = sel ? gen1  : gen0;
    done_s = sel ? done1 : done0;
    err_s  = sel ? err1  : err0;
    cnt_s  = sel ? cnt1  : cnt0;
  end

  always @(negedge clk) if (done_s === 1'b1) n_done++;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // gaps: 3 idle cycles after the 3rd bit and 2 before parity; noise: start held in DATA and DONE
  task automatic run_frame(input string nm, input logic [7:0] d, input logic p,
                           input bit gaps, input bit noise, input logic eg, input logic ee);
    int steps = 0;
    int d0    = n_done;
    start = 1'b1; bit_vld = 1'b0; bit_in = 1'b0;
    step(); steps++;
    chk({nm, " busy_after_start"}, 32'(busy_s), 1);
    chk({nm, " cnt_after_start"}, 32'(cnt_s), 0);
    start = noise;
    for (int i = 0; i < 8; i++) begin
      bit_in = d[7-i]; bit_vld = 1'b1;
      step(); steps++;
      if (gaps && i == 2) begin
        bit_vld = 1'b0;
        for (int g = 0; g < 3; g++) begin
          step(); steps++;
          chk({nm, " cnt_hold"}, 32'(cnt_s), 3);
        end
      end
    end
    bit_vld = 1'b0;
    if (gaps) for (int g = 0; g < 2; g++) begin step(); steps++; end
    chk({nm, " cnt_in_par"}, 32'(cnt_s), 8);
    chk({nm, " busy_in_par"}, 32'(busy_s), 1);
    chk({nm, " par_gen"}, 32'(gen_s), 32'(eg));
    chk({nm, " done_early"}, 32'(done_s), 0);
    bit_in = p; bit_vld = 1'b1;
    step(); steps++;
    bit_vld = 1'b0;
    chk({nm, " done"}, 32'(done_s), 1);
    chk({nm, " done_latency"}, 32'(steps), gaps ? 15 : 10);
    chk({nm, " par_err"}, 32'(err_s), 32'(ee));
    chk({nm, " busy_in_done"}, 32'(busy_s), 0);
    step();
    start = 1'b0;
    chk({nm, " done_clear"}, 32'(done_s), 0);
    chk({nm, " idle_after_done"}, 32'(busy_s), 0);
    chk({nm, " done_pulses"}, 32'(n_done - d0), 1);
    chk({nm, " par_err_held"}, 32'(err_s), 32'(ee));
  endtask

  typedef struct {
    string      nm;
    logic       sel;
    logic [7:0] d;
    logic       p;
    logic       eg;
    logic       ee;
  } vec_t;
  vec_t vt[9];

  initial begin
    vt[0] = '{"even_ok",      1'b0, 8'b1011_0010, 1'b0, 1'b0, 1'b0};
    vt[1] = '{"even_bad",     1'b0, 8'b1011_0010, 1'b1, 1'b0, 1'b1};
    vt[2] = '{"even_ff_ok",   1'b0, 8'b1111_1111, 1'b0, 1'b0, 1'b0};
    vt[3] = '{"even_01_ok",   1'b0, 8'b0000_0001, 1'b1, 1'b1, 1'b0};
    vt[4] = '{"even_07_bad",  1'b0, 8'b0000_0111, 1'b0, 1'b1, 1'b1};
    vt[5] = '{"odd_00_ok",    1'b1, 8'b0000_0000, 1'b1, 1'b1, 1'b0};
    vt[6] = '{"odd_00_bad",   1'b1, 8'b0000_0000, 1'b0, 1'b1, 1'b1};
    vt[7] = '{"odd_01_ok",    1'b1, 8'b0000_0001, 1'b0, 1'b0, 1'b0};
    vt[8] = '{"odd_c0_bad",   1'b1, 8'b1100_0000, 1'b0, 1'b1, 1'b1};

    sel = 1'b0;
    rst = 1'b1; start = 1'b1; bit_vld = 1'b1; bit_in = 1'b1;
    step();
    start = 1'b0; bit_vld = 1'b0;
    step();
    chk("rst busy0", 32'(busy0), 0);
    chk("rst done0", 32'(done0), 0);
    chk("rst err0", 32'(err0), 0);
    chk("rst cnt0", 32'(cnt0), 0);
    chk("rst gen0", 32'(gen0), 0);
    chk("rst gen1", 32'(gen1), 1);
    chk("rst busy1", 32'(busy1), 0);
    rst = 1'b0;
    step();
    chk("idle busy0", 32'(busy0), 0);

    foreach (vt[k]) begin
      sel = vt[k].sel;
      run_frame(vt[k].nm, vt[k].d, vt[k].p, 1'b0, 1'b0, vt[k].eg, vt[k].ee);
    end

    // Error verdict persists until the next accepted start.
    sel = 1'b0;
    run_frame("err_hold", 8'b1011_0010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (20) step();
    chk("err_hold 20cyc", 32'(err0), 1);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("err_clr_on_start", 32'(err0), 0);
    chk("err_clr busy", 32'(busy0), 1);
    rst = 1'b1; step(); rst = 1'b0;

    run_frame("gaps", 8'b1011_0010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset mid-frame discards partial data.
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 4; i++) begin bit_in = 1'b1; bit_vld = 1'b1; step(); end
    chk("mid cnt_before_rst", 32'(cnt0), 4);
    bit_vld = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid rst busy", 32'(busy0), 0);
    chk("mid rst cnt", 32'(cnt0), 0);
    chk("mid rst done", 32'(done0), 0);
    run_frame("after_rst", 8'b1011_0010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Odd instance with start held through DATA and DONE.
    sel = 1'b1;
    run_frame("odd_noise", 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);

    // A bit presented together with start is not counted.
    start = 1'b1; bit_vld = 1'b1; bit_in = 1'b1;
    step();
    start = 1'b0; bit_vld = 1'b0;
    chk("start_vld cnt", 32'(cnt1), 0);
    chk("start_vld busy", 32'(busy1), 1);
    chk("start_vld gen", 32'(gen1), 1);
    step();
    chk("start_vld cnt_hold", 32'(cnt1), 0);
    rst = 1'b1; step(); rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
